fetch_mem_unit: RTL and testbench

- Datapath-side responder to the CPU controller's control strobes (PC_en, fetch, rom_ena/rom_read, ram_ena/ram_read/ram_write, ad_sel).
- Holds the program counter and the 16-bit instruction register, assembled from two byte fetches.
- Provides the address mux, a byte-wide program ROM (loadable) and a byte-wide data RAM.
- Returns the opcode ins[2:0] to the controller and flags protocol violations on the strobe interface.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/byte_mem.sv | 25 ++
 rtl/fetch_mem_unit.sv | 115 +++++++++++
 tb/tb_fetch_mem_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch strobe encodings, architectural widths.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 13;
  localparam int unsigned IR_W       = 16;

  typedef enum logic [2:0] {
    NOP = 3'b000,
    LDO = 3'b001,
    LDA = 3'b010,
    STO = 3'b011,
    PRE = 3'b100,
    ADD = 3'b101,
    LDM = 3'b110,
    HLT = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH_NONE = 2'b00,
    FETCH_HI   = 2'b01,
    FETCH_LO   = 2'b10,
    FETCH_ILL  = 2'b11
  } fetch_e;

endpackage

// File: rtl/byte_mem.sv
// Byte-wide storage array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module byte_mem #(
  parameter int unsigned AW = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [7:0] r_mem [DEPTH];

  // Synchronous write; a same-cycle read sees the pre-write contents
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_mem_unit.sv
// Datapath responder to the CPU controller: PC, two-byte instruction register,
// address mux, program ROM, data RAM and a sticky strobe-protocol error flag.
module fetch_mem_unit #(
  parameter int unsigned ROM_AW = 8,
  parameter int unsigned RAM_AW = 8,
  parameter int unsigned ADDR_W = cpu_pkg::CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_en,
  input  logic [1:0]        fetch,
  input  logic              ad_sel,
  input  logic              rom_ena,
  input  logic              rom_read,
  input  logic              ram_ena,
  input  logic              ram_read,
  input  logic              ram_write,
  input  logic [7:0]        acc_data,
  input  logic              prog_we,
  input  logic [ROM_AW-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  output logic [2:0]        ins,
  output logic [ADDR_W-1:0] ir_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_bus,
  output logic              data_valid,
  output logic              proto_err
);

  import cpu_pkg::*;

  logic [ADDR_W-1:0] r_pc;
  logic [IR_W-1:0]   r_ir;
  logic              r_proto_err;

  logic              w_rd_rom;
  logic              w_rd_ram;
  logic              w_ram_we;
  logic              w_err;
  logic [7:0]        w_rom_q;
  logic [7:0]        w_ram_q;

  assign w_rd_rom = rom_ena & rom_read;
  assign w_rd_ram = ram_ena & ram_read;
  assign w_ram_we = ram_ena & ram_write;

  assign addr = ad_sel ? r_ir[ADDR_W-1:0] : r_pc;

  // Read mux: exactly one active reader drives the bus, anything else is idle
  always_comb begin
    data_bus   = 8'h00;
    data_valid = 1'b0;
    if (w_rd_rom && !w_rd_ram) begin
      data_bus   = w_rom_q;
      data_valid = 1'b1;
    end else if (w_rd_ram && !w_rd_rom) begin
      data_bus   = w_ram_q;
      data_valid = 1'b1;
    end
  end

  // Strobe combinations the controller must never issue
  assign w_err = (ram_ena & ram_read & ram_write)
               | (w_rd_rom & w_rd_ram)
               | (fetch == FETCH_ILL)
               | ((fetch != FETCH_NONE) & ~w_rd_rom)
               | (PC_en & ram_write);

  // Program counter, wraps naturally at the architectural width
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_pc <= '0;
    else if (PC_en) r_pc <= r_pc + ADDR_W'(1);
  end

  // Instruction register assembled from two ROM byte fetches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir <= '0;
    end else if (w_rd_rom) begin
      if (fetch == FETCH_HI)      r_ir[15:8] <= data_bus;
      else if (fetch == FETCH_LO) r_ir[7:0]  <= data_bus;
    end
  end

  // Sticky protocol-violation flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_proto_err <= 1'b0;
    else if (w_err) r_proto_err <= 1'b1;
  end

  assign pc        = r_pc;
  assign ins       = r_ir[15:13];
  assign ir_addr   = r_ir[ADDR_W-1:0];
  assign proto_err = r_proto_err;

  byte_mem #(.AW(ROM_AW)) u_rom (
    .i_clk   (clk),
    .i_we    (prog_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (addr[ROM_AW-1:0]),
    .o_rdata (w_rom_q)
  );

  byte_mem #(.AW(RAM_AW)) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_waddr (addr[RAM_AW-1:0]),
    .i_wdata (acc_data),
    .i_raddr (addr[RAM_AW-1:0]),
    .o_rdata (w_ram_q)
  );

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Bench for fetch_mem_unit: directed scenarios plus randomized strobes,
// all outputs compared every cycle against a behavioural model.
module tb_fetch_mem_unit;

  logic        clk;
  logic        rst;
  logic        PC_en;
  logic [1:0]  fetch;
  logic        ad_sel;
  logic        rom_ena;
  logic        rom_read;
  logic        ram_ena;
  logic        ram_read;
  logic        ram_write;
  logic [7:0]  acc_data;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [2:0]  ins;
  logic [12:0] ir_addr;
  logic [12:0] pc;
  logic [12:0] addr;
  logic [7:0]  data_bus;
  logic        data_valid;
  logic        proto_err;

  fetch_mem_unit dut (
    .clk        (clk),
    .rst        (rst),
    .PC_en      (PC_en),
    .fetch      (fetch),
    .ad_sel     (ad_sel),
    .rom_ena    (rom_ena),
    .rom_read   (rom_read),
    .ram_ena    (ram_ena),
    .ram_read   (ram_read),
    .ram_write  (ram_write),
    .acc_data   (acc_data),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .ins        (ins),
    .ir_addr    (ir_addr),
    .pc         (pc),
    .addr       (addr),
    .data_bus   (data_bus),
    .data_valid (data_valid),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Behavioural model state
  int unsigned m_pc;
  logic [15:0] m_ir;
  logic        m_perr;
  logic [7:0]  m_rom [256];
  logic [7:0]  m_ram [256];
  logic [7:0]  m_bus;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    PC_en = 1'b0; fetch = 2'b00; ad_sel = 1'b0;
    rom_ena = 1'b0; rom_read = 1'b0;
    ram_ena = 1'b0; ram_read = 1'b0; ram_write = 1'b0;
    acc_data = 8'h00; prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
  endtask

  function automatic int unsigned m_addr();
    return ad_sel ? int'(m_ir % 16'h2000) : m_pc;
  endfunction

  // Compare every output against the model in the middle of the cycle
  task automatic sample();
    bit rr, rm;
    int unsigned a;
    @(negedge clk);
    rr = rom_ena && rom_read;
    rm = ram_ena && ram_read;
    a  = m_addr();
    if (rr && !rm)      m_bus = m_rom[a % 256];
    else if (rm && !rr) m_bus = m_ram[a % 256];
    else                m_bus = 8'h00;
    chk("pc",         32'(pc),         32'(m_pc));
    chk("ins",        32'(ins),        32'(m_ir / 16'h2000));
    chk("ir_addr",    32'(ir_addr),    32'(m_ir % 16'h2000));
    chk("addr",       32'(addr),       32'(a));
    chk("data_bus",   32'(data_bus),   32'(m_bus));
    chk("data_valid", 32'(data_valid), 32'(rr != rm));
    chk("proto_err",  32'(proto_err),  32'(m_perr));
  endtask

  // Advance the model by one clock using the inputs held this cycle
  task automatic clock();
    bit rr, rm;
    int unsigned a;
    @(posedge clk);
    rr = rom_ena && rom_read;
    rm = ram_ena && ram_read;
    a  = m_addr();
    if ((ram_ena && ram_read && ram_write) || (rr && rm) || fetch == 2'b11 ||
        (fetch != 2'b00 && !rr) || (PC_en && ram_write))
      m_perr = 1'b1;
    if (rr && fetch == 2'b01) m_ir = {m_bus, m_ir[7:0]};
    if (rr && fetch == 2'b10) m_ir = {m_ir[15:8], m_bus};
    if (ram_ena && ram_write) m_ram[a % 256] = acc_data;
    if (prog_we) m_rom[prog_addr] = prog_data;
    if (PC_en) m_pc = (m_pc + 1) % 8192;
    #1;
  endtask

  task automatic step();
    sample();
    clock();
  endtask

  // Asynchronous reset: outputs must clear with no clock edge
  task automatic do_reset();
    idle();
    rst = 1'b0;
    #2;
    m_pc = 0; m_ir = 16'h0000; m_perr = 1'b0;
    chk("rst_pc",        32'(pc),         32'd0);
    chk("rst_ins",       32'(ins),        32'd0);
    chk("rst_ir_addr",   32'(ir_addr),    32'd0);
    chk("rst_proto_err", 32'(proto_err),  32'd0);
    chk("rst_addr",      32'(addr),       32'd0);
    chk("rst_data_bus",  32'(data_bus),   32'd0);
    chk("rst_valid",     32'(data_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    m_pc = 0; m_ir = 16'h0000; m_perr = 1'b0; m_bus = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Load the program ROM
    for (int i = 0; i < 256; i++) begin
      idle();
      prog_we = 1'b1; prog_addr = 8'(i);
      prog_data = (i == 0) ? 8'hA0 : (i == 1) ? 8'h2F : (i == 255) ? 8'hC3 : 8'($urandom);
      step();
    end
    // Fill RAM at pc-addressed locations, stepping pc between writes
    for (int i = 0; i < 256; i++) begin
      idle(); ram_ena = 1'b1; ram_write = 1'b1; acc_data = 8'($urandom);
      step();
      idle(); PC_en = 1'b1;
      step();
    end

    // Mid-run reset (pc is non-zero here)
    do_reset();

    // Two-byte fetch
    idle(); fetch = 2'b01; rom_ena = 1'b1; rom_read = 1'b1; step();
    idle(); PC_en = 1'b1; step();
    idle(); fetch = 2'b10; rom_ena = 1'b1; rom_read = 1'b1; step();
    idle(); PC_en = 1'b1; step();
    idle(); sample();
    chk("fetch_ins",     32'(ins),     32'd5);
    chk("fetch_ir_addr", 32'(ir_addr), 32'h002F);
    chk("fetch_pc",      32'(pc),      32'd2);
    clock();

    // RAM store then load through the IR operand
    idle(); ad_sel = 1'b1; ram_ena = 1'b1; ram_write = 1'b1; acc_data = 8'h5A; step();
    idle(); ad_sel = 1'b1; ram_ena = 1'b1; ram_read = 1'b1; sample();
    chk("ram_data",  32'(data_bus),   32'h5A);
    chk("ram_valid", 32'(data_valid), 32'd1);
    chk("ram_addr",  32'(addr),       32'h002F);
    clock();

    // PC wrap and ROM index wrap
    idle(); PC_en = 1'b1;
    while (m_pc != 13'h1FFF) step();
    idle(); rom_ena = 1'b1; rom_read = 1'b1; sample();
    chk("wrap_addr", 32'(addr),     32'h1FFF);
    chk("wrap_rom",  32'(data_bus), 32'hC3);
    clock();
    idle(); PC_en = 1'b1; step();
    idle(); sample();
    chk("wrap_pc", 32'(pc), 32'd0);
    clock();

    // ROM load while reading the same address
    idle(); rom_ena = 1'b1; rom_read = 1'b1;
    prog_we = 1'b1; prog_addr = 8'h00; prog_data = 8'h77; sample();
    chk("romld_old", 32'(data_bus), 32'hA0);
    clock();
    idle(); rom_ena = 1'b1; rom_read = 1'b1; sample();
    chk("romld_new", 32'(data_bus), 32'h77);
    clock();

    // Read contention
    idle(); sample();
    chk("perr_clean", 32'(proto_err), 32'd0);
    clock();
    idle(); rom_ena = 1'b1; rom_read = 1'b1; ram_ena = 1'b1; ram_read = 1'b1; sample();
    chk("cont_valid", 32'(data_valid), 32'd0);
    clock();
    idle(); sample();
    chk("cont_perr", 32'(proto_err), 32'd1);
    clock();
    idle(); step(); sample();
    chk("cont_sticky", 32'(proto_err), 32'd1);
    clock();

    // Illegal fetch encoding
    do_reset();
    idle(); fetch = 2'b11; rom_ena = 1'b1; rom_read = 1'b1; step();
    idle(); sample();
    chk("fetch11_perr", 32'(proto_err), 32'd1);
    clock();

    // Randomized strobes, occasional resets (including mid-fetch)
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int unsigned f;
      if ($urandom_range(0, 63) == 0) do_reset();
      idle();
      PC_en     = ($urandom_range(0, 2) == 0);
      f         = $urandom_range(0, 7);
      fetch     = (f < 4) ? 2'b00 : (f < 6) ? 2'b01 : (f == 6) ? 2'b10 :
                  ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
      ad_sel    = 1'($urandom_range(0, 1));
      rom_ena   = ($urandom_range(0, 3) != 0);
      rom_read  = ($urandom_range(0, 3) != 0);
      ram_ena   = 1'($urandom_range(0, 1));
      ram_read  = ($urandom_range(0, 2) == 0);
      ram_write = ($urandom_range(0, 3) == 0);
      acc_data  = 8'($urandom);
      prog_we   = ($urandom_range(0, 7) == 0);
      prog_addr = 8'($urandom);
      prog_data = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
